// File: rtl/tnn_seq_ctrl.sv
// Streaming sequencer around the Har_tnn1_tnndirect ternary-NN core: load a vector, run the core, hand back its class.
// Optional per-class result histogram enabled by defining TNN_SEQ_HIST_EN.
module tnn_seq_ctrl #(
  parameter int FEAT_CNT      = 12,
  parameter int FEAT_BITS     = 4,
  parameter int HIDDEN_CNT    = 40,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = FEAT_CNT + HIDDEN_CNT,
  parameter int HIST_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]      in_data,
  output logic [FEAT_BITS*FEAT_CNT-1:0]      core_data,
  output logic                               core_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]       core_prediction,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]       out_class,
  output logic                               busy
`ifdef TNN_SEQ_HIST_EN
  ,
  output logic [CLASS_CNT*HIST_BITS-1:0]     hist
`endif
);

  localparam int DATA_W = FEAT_BITS * FEAT_CNT;
  localparam int CLS_W  = $clog2(CLASS_CNT);
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CLS_W-1:0]   class_q, class_d;
  logic               accept;
  logic               out_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    class_d  = class_q;
    // A finishing result may hand over to the next vector in the same cycle.
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    out_hs   = (state_q == DONE) && out_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          class_d = core_prediction;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_data = data_q;
  assign out_class = class_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == LOAD) || (state_q == RUN);
  // Core held in reset outside RUN so it starts each vector from a clean state.
  assign core_rst  = (state_q != RUN);

`ifdef TNN_SEQ_HIST_EN
  logic [HIST_BITS-1:0] hist_q [CLASS_CNT];
  logic [HIST_BITS-1:0] hist_d [CLASS_CNT];

  function automatic logic [HIST_BITS-1:0] sat_inc(input logic [HIST_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < CLASS_CNT; c++) begin
      hist_d[c] = hist_q[c];
      if (out_hs && (int'(class_q) == c)) hist_d[c] = sat_inc(hist_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CLASS_CNT; c++) hist_q[c] <= '0;
    end else begin
      for (int c = 0; c < CLASS_CNT; c++) hist_q[c] <= hist_d[c];
    end
  end

  always_comb begin
    hist = '0;
    for (int c = 0; c < CLASS_CNT; c++) hist[c*HIST_BITS +: HIST_BITS] = hist_q[c];
  end
`endif

endmodule

// File: tb/tb_tnn_seq_ctrl.sv
// Directed bench for tnn_seq_ctrl with a behavioural core whose prediction is only valid after the settle time.
// Histogram checks are compiled in when TNN_SEQ_HIST_EN is defined.
module tb_tnn_seq_ctrl;

  localparam int SETTLE = 52;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [47:0] core_data;
  logic        core_rst;
  logic [2:0]  core_prediction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_class;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

`ifdef TNN_SEQ_HIST_EN
  logic [95:0] hist;
  logic [11:0] hist_n;
  logic        n_in_ready, n_core_rst, n_out_valid, n_busy;
  logic [47:0] n_core_data;
  logic [2:0]  n_out_class;
`endif

  tnn_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_data(core_data), .core_rst(core_rst), .core_prediction(core_prediction),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .busy(busy)
`ifdef TNN_SEQ_HIST_EN
    , .hist(hist)
`endif
  );

`ifdef TNN_SEQ_HIST_EN
  tnn_seq_ctrl #(.HIST_BITS(2)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .core_data(n_core_data), .core_rst(n_core_rst), .core_prediction(core_prediction),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_class(n_out_class), .busy(n_busy),
    .hist(hist_n)
  );
`endif

  // Core model: class = feature nibble 3 mod 6, but only after SETTLE cycles out of reset; 7 otherwise.
  logic [5:0] mcnt;
  always_ff @(posedge clk) begin
    if (core_rst) mcnt <= '0;
    else if (mcnt != 6'h3f) mcnt <= mcnt + 1'b1;
  end
  assign core_prediction = (!core_rst && (mcnt >= 6'(SETTLE - 1))) ? 3'(core_data[15:12] % 4'd6) : 3'd7;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one vector with out_ready high; verify latency, core reset window, class and return to idle.
  task automatic run_one(input logic [47:0] vec, input logic [2:0] cls);
    int k, lo, vcyc, bad;
    @(negedge clk);
    in_valid = 1'b1; in_data = vec; out_ready = 1'b1;
    check_eq("acc_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1; lo = 0; vcyc = 0; bad = 0;
    while (k <= 80 && vcyc == 0) begin
      if (!core_rst) lo++;
      if (busy && core_data !== vec) bad++;
      if (out_valid) begin
        vcyc = k;
        check_eq("cls", out_class, cls);
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check_eq("lat", vcyc, SETTLE + 2);
    check_eq("rst_lo", lo, SETTLE);
    check_eq("data_stable", bad, 0);
    @(negedge clk);
    check_eq("idle_ov", out_valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_rdy", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] bv [5];
    logic [2:0]  bc [5];
    int acc [5];
    int ai, ri, cyc, k, seen;
    bit upd;
    logic [95:0] hexp;
    logic [11:0] hnexp;

    bv[0] = 48'h000000000000; bc[0] = 3'd0;
    bv[1] = 48'h111111111111; bc[1] = 3'd1;
    bv[2] = 48'h000000005000; bc[2] = 3'd5;
    bv[3] = 48'hABCDEF018234; bc[3] = 3'd2;
    bv[4] = 48'h0F0F0F0FA0F0; bc[4] = 3'd4;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      check_eq("rst_rdy", in_ready, 1);
      check_eq("rst_ov", out_valid, 0);
      check_eq("rst_core_rst", core_rst, 1);
      check_eq("rst_busy", busy, 0);
      @(negedge clk);
    end
    check_eq("rst_data", core_data, 0);
    check_eq("rst_class", out_class, 0);

    run_one(48'h123456789ABC, 3'd3);

    // Output back-pressure
    in_valid = 1'b1; in_data = 48'hFEDCBA987654; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp_lat", k, SETTLE + 1);
    repeat (20) begin
      check_eq("bp_ov", out_valid, 1);
      check_eq("bp_cls", out_class, 1);
      check_eq("bp_rdy", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_rel_rdy", in_ready, 1);
    check_eq("bp_rel_ov", out_valid, 1);
    @(negedge clk);
    check_eq("bp_after_ov", out_valid, 0);
    check_eq("bp_after_busy", busy, 0);
    check_eq("bp_after_rdy", in_ready, 1);

    // Back-to-back stream
    ai = 0; ri = 0; cyc = 0; upd = 1'b0;
    in_data = bv[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (ri < 5 && cyc < 400) begin
      if (in_valid && in_ready && ai < 5) begin
        if (ai > 0) begin
          check_eq("b2b_coinc", out_valid, 1);
          check_eq("b2b_gap", cyc - acc[ai-1], SETTLE + 2);
        end
        acc[ai] = cyc;
        ai++;
        upd = 1'b1;
      end
      if (out_valid) begin
        check_eq("b2b_cls", out_class, bc[ri]);
        ri++;
      end
      @(negedge clk);
      cyc++;
      if (upd) begin
        upd = 1'b0;
        if (ai < 5) in_data = bv[ai];
        else in_valid = 1'b0;
      end
    end
    check_eq("b2b_results", ri, 5);
    check_eq("b2b_accepts", ai, 5);
    check_eq("b2b_end_ov", out_valid, 0);
    check_eq("b2b_end_busy", busy, 0);

    // Reset in the middle of a run
    in_valid = 1'b1; in_data = 48'h123456789ABC; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_core_rst", core_rst, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_core_rst", core_rst, 1);
    check_eq("mid_rst_rdy", in_ready, 1);
    check_eq("mid_rst_data", core_data, 0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("mid_no_result", seen, 0);
    run_one(48'h123456789ABC, 3'd3);

`ifdef TNN_SEQ_HIST_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("hist_rst", hist, 0);
    run_one(48'h000000002000, 3'd2);
    run_one(48'h000000008000, 3'd2);
    run_one(48'hFFFFFFFF2FFF, 3'd2);
    run_one(48'h000000008123, 3'd2);
    run_one(48'h00000000B000, 3'd5);
    hexp = '0; hexp[32 +: 16] = 16'd4; hexp[80 +: 16] = 16'd1;
    check_eq("hist_main", hist, hexp);
    hnexp = '0; hnexp[4 +: 2] = 2'd3; hnexp[10 +: 2] = 2'd1;
    check_eq("hist_narrow", hist_n, hnexp);
    run_one(48'h000000002000, 3'd2);
    hexp[32 +: 16] = 16'd5;
    check_eq("hist_main5", hist, hexp);
    check_eq("hist_sat", hist_n, hnexp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
